// File: rtl/fm_mot_pkg.sv
// Shared types and default widths for the FM modulation differencing block.
package fm_mot_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SYNC  = 2'd1,
        ACCUM = 2'd2
    } state_t;

    localparam int SIGSIZE_DEF  = 16;
    localparam int ACCWIDTH_DEF = 40;
    localparam int SHIFT_DEF    = 0;
    localparam int NPER_W       = 16;

endpackage

// File: rtl/sat_trunc.sv
// Signed saturating narrowing from IW to OW bits (IW >= OW).
module sat_trunc #(
    parameter int IW = 41,
    parameter int OW = 16
) (
    input  logic signed [IW-1:0] din,
    output logic signed [OW-1:0] dout
);

    logic fits;

    // The value fits when every bit above the output sign bit matches the input sign.
    assign fits = (din[IW-1:OW-1] == {(IW-OW+1){din[IW-1]}});

    // Clamp to the most positive / most negative code instead of wrapping.
    assign dout = fits        ? din[OW-1:0] :
                  din[IW-1]   ? {1'b1, {(OW-1){1'b0}}} :
                                {1'b0, {(OW-1){1'b1}}};

endmodule

// File: rtl/fm_mot_diff.sv
// Synchronous FM demodulator: sums samples per modulation phase over n_per
// FM periods, reports high-minus-low difference and its change between
// successive measurements.
module fm_mot_diff
    import fm_mot_pkg::*;
#(
    parameter int SIGSIZE  = SIGSIZE_DEF,
    parameter int ACCWIDTH = ACCWIDTH_DEF,
    parameter int SHIFT    = SHIFT_DEF
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic                      fm_sq,
    input  logic [NPER_W-1:0]         n_per,
    input  logic signed [SIGSIZE-1:0] sig_in,
    output logic signed [SIGSIZE-1:0] out0,
    output logic signed [SIGSIZE-1:0] out1,
    output logic                      trig
);

    state_t state_q, state_d;

    logic                       fm_sq_d;
    logic                       rise, start, in_acc, done, publish;
    logic [NPER_W-1:0]          per_cnt, target, target_n;
    logic signed [ACCWIDTH-1:0] acc_hi, acc_lo, sig_ext;
    logic signed [ACCWIDTH:0]   diff_raw, diff_sh;
    logic signed [SIGSIZE-1:0]  out0_new, out1_new;
    logic signed [SIGSIZE:0]    d1;
    logic [1:0]                 vld_pipe;   // [0]: raw diff held, [1]: outputs updated
    logic                       first_q;

    assign rise     = fm_sq & ~fm_sq_d;
    assign start    = (state_q == SYNC) & en & rise;
    assign in_acc   = (state_q == ACCUM) & en;
    assign done     = in_acc & rise & ((per_cnt + 16'd1) == target);
    assign publish  = vld_pipe[0] & en;
    assign target_n = (n_per == '0) ? NPER_W'(1) : n_per;
    assign sig_ext  = {{(ACCWIDTH-SIGSIZE){sig_in[SIGSIZE-1]}}, sig_in};
    assign diff_sh  = diff_raw >>> SHIFT;
    assign d1       = {out0_new[SIGSIZE-1], out0_new} - {out0[SIGSIZE-1], out0};
    assign trig     = vld_pipe[1];

    sat_trunc #(.IW(ACCWIDTH+1), .OW(SIGSIZE)) u_sat0 (.din(diff_sh), .dout(out0_new));
    sat_trunc #(.IW(SIGSIZE+1),  .OW(SIGSIZE)) u_sat1 (.din(d1),      .dout(out1_new));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next state: wait for enable, lock onto the first rising edge, then run freely.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (en) state_d = SYNC;
            SYNC:    if (!en) state_d = IDLE; else if (rise) state_d = ACCUM;
            ACCUM:   if (!en) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Phase accumulators and period counter; a completing edge restarts them
    // with its own sample so consecutive measurements are gapless.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fm_sq_d  <= 1'b0;
            per_cnt  <= '0;
            target   <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            diff_raw <= '0;
        end else begin
            fm_sq_d <= fm_sq;
            if (done) diff_raw <= {acc_hi[ACCWIDTH-1], acc_hi} - {acc_lo[ACCWIDTH-1], acc_lo};
            if (start || done) begin
                target  <= target_n;
                per_cnt <= '0;
                acc_hi  <= sig_ext;   // fm_sq is high on a rising edge
                acc_lo  <= '0;
            end else if (in_acc) begin
                if (rise) per_cnt <= per_cnt + 16'd1;
                if (fm_sq) acc_hi <= acc_hi + sig_ext;
                else       acc_lo <= acc_lo + sig_ext;
            end else begin
                per_cnt <= '0;
                target  <= '0;
                acc_hi  <= '0;
                acc_lo  <= '0;
            end
        end
    end

    // Result pipeline; dropping en kills any result still in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            out0     <= '0;
            out1     <= '0;
            first_q  <= 1'b1;
        end else begin
            vld_pipe <= {publish, done};
            if (state_q == IDLE) first_q <= 1'b1;
            else if (publish)    first_q <= 1'b0;
            if (publish) begin
                out0 <= out0_new;
                out1 <= first_q ? '0 : out1_new;
            end
        end
    end

endmodule

// File: tb/tb_fm_mot_diff.sv
// Randomised and directed bench for fm_mot_diff against a window-sum model.
module tb_fm_mot_diff;

    localparam int SIGSIZE  = 16;
    localparam int ACCWIDTH = 40;
    localparam int SHIFT    = 0;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               en = 1'b0;
    logic               fm_sq = 1'b0;
    logic [15:0]        n_per = 16'd1;
    logic signed [15:0] sig_in = '0;
    logic signed [15:0] out0, out1;
    logic               trig;

    fm_mot_diff #(.SIGSIZE(SIGSIZE), .ACCWIDTH(ACCWIDTH), .SHIFT(SHIFT)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .fm_sq(fm_sq), .n_per(n_per),
        .sig_in(sig_in), .out0(out0), .out1(out1), .trig(trig)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    task automatic check(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ---------------- stimulus generator ----------------
    int gen_mode = 0;   // 0: regular square wave with per-phase amplitudes, 1: random
    int half = 4, ph = 0, amp_hi = 0, amp_lo = 0;

    always @(posedge clk) begin
        cyc++;
        #1;
        if (gen_mode == 0) begin
            ph     = (ph + 1) % (2 * half);
            fm_sq  = (ph < half);
            sig_in = fm_sq ? 16'(amp_hi) : 16'(amp_lo);
        end else begin
            if ($urandom_range(2) == 0) fm_sq = ~fm_sq;
            sig_in = 16'($urandom);
            n_per  = 16'($urandom_range(3));
        end
    end

    // ---------------- behavioural model ----------------
    // Keeps the current window as a list of (sample, phase) and schedules
    // each finished measurement for publication one edge later.
    typedef struct { int due; longint d; } pend_t;
    pend_t  pend[$];
    longint win_v[$];
    bit     win_h[$];
    int     mode = 0, rises = 0, tgt = 0, p = 0;
    bit     prev_fm = 0, first = 1;
    longint e0 = 0, e1 = 0, et = 0;

    function automatic longint sat(input longint v);
        if (v > 32767)  return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    always @(posedge clk) begin : model
        bit     rise;
        longint s_hi, s_lo, o0;
        pend_t  pe;
        p++;
        rise = fm_sq && !prev_fm;
        et   = 0;
        if (!rst_n) begin
            mode = 0; rises = 0; first = 1; prev_fm = 0;
            e0 = 0; e1 = 0;
            pend.delete(); win_v.delete(); win_h.delete();
        end else begin
            if (!en) begin
                mode = 0; first = 1;
                pend.delete(); win_v.delete(); win_h.delete();
            end else begin
                if (pend.size() > 0 && pend[0].due == p) begin
                    o0 = sat(pend[0].d >>> SHIFT);
                    e1 = first ? 0 : sat(o0 - e0);
                    e0 = o0;
                    et = 1;
                    first = 0;
                    void'(pend.pop_front());
                end
                if (mode == 0) begin
                    mode = 1; first = 1;
                end else if (mode == 1) begin
                    if (rise) begin
                        win_v.delete(); win_h.delete();
                        win_v.push_back(longint'(sig_in)); win_h.push_back(1'b1);
                        rises = 0; tgt = (n_per == 0) ? 1 : int'(n_per); mode = 2;
                    end
                end else begin
                    if (rise) rises++;
                    if (rise && rises == tgt) begin
                        s_hi = 0; s_lo = 0;
                        for (int i = 0; i < win_v.size(); i++)
                            if (win_h[i]) s_hi += win_v[i]; else s_lo += win_v[i];
                        pe.due = p + 1; pe.d = s_hi - s_lo;
                        pend.push_back(pe);
                        win_v.delete(); win_h.delete();
                        win_v.push_back(longint'(sig_in)); win_h.push_back(1'b1);
                        rises = 0; tgt = (n_per == 0) ? 1 : int'(n_per);
                    end else begin
                        win_v.push_back(longint'(sig_in)); win_h.push_back(fm_sq);
                    end
                end
            end
            prev_fm = fm_sq;
        end
    end

    // ---------------- per-cycle compare ----------------
    bit prev_trig = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst_out0", out0, 0);
            check("rst_out1", out1, 0);
            check("rst_trig", trig, 0);
            prev_trig = 0;
        end else begin
            check("out0", out0, e0);
            check("out1", out1, e1);
            check("trig", trig, et);
            if (trig) check("trig_back_to_back", prev_trig, 0);
            prev_trig = trig;
        end
    end

    // ---------------- directed sequence helpers ----------------
    task automatic wait_trig(input int maxc, output int at);
        at = -1;
        for (int k = 0; k < maxc; k++) begin
            @(negedge clk);
            if (trig) begin
                at = cyc;
                return;
            end
        end
        n_cmp++;
        n_bad++;
        $display("FAIL trig_timeout: no trig within %0d cycles (cycle %0d)", maxc, cyc);
    endtask

    task automatic set_en(input logic v);
        @(posedge clk);
        #1 en = v;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, t1, trel;
        longint h0, h1;

        // reset state
        gen_mode = 0; half = 4; amp_hi = 100; amp_lo = 100; n_per = 16'd1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_out0", out0, 0);
        check("reset_out1", out1, 0);
        check("reset_trig", trig, 0);
        @(posedge clk); #1 rst_n = 1'b1;

        // constant input, n_per=1, period 8
        set_en(1'b1);
        wait_trig(40, t0);
        check("A_out0", out0, 0);
        check("A_out1", out1, 0);
        wait_trig(20, t1);
        check("A_period", t1 - t0, 8);

        // +/-100, n_per=2
        set_en(1'b0);
        amp_hi = 100; amp_lo = -100; n_per = 16'd2;
        set_en(1'b1);
        wait_trig(80, t0);
        check("B_out0_first", out0, 1600);
        check("B_out1_first", out1, 0);
        wait_trig(40, t1);
        check("B_out0", out0, 1600);
        check("B_out1", out1, 0);
        check("B_period", t1 - t0, 16);

        // full scale saturation, then amplitude step to zero
        set_en(1'b0);
        half = 32; n_per = 16'd4; amp_hi = 32767; amp_lo = -32768;
        set_en(1'b1);
        wait_trig(700, t0);
        check("C_out0_sat", out0, 32767);
        check("C_out1_first", out1, 0);
        amp_hi = 0; amp_lo = 0;
        wait_trig(300, t0);
        check("C_out0_edge", out0, 32767);
        wait_trig(300, t0);
        check("C_out0_zero", out0, 0);
        check("C_out1_step", out1, -32767);

        // n_per=0 behaves as n_per=1
        set_en(1'b0);
        half = 4; n_per = 16'd0; amp_hi = 100; amp_lo = -100;
        set_en(1'b1);
        wait_trig(40, t0);
        wait_trig(20, t1);
        check("D_out0", out0, 800);
        check("D_period", t1 - t0, 8);

        // en dropped during the cycle after a completing edge
        wait_trig(20, t0);
        h0 = out0; h1 = out1;
        repeat (7) @(posedge clk);
        #1 en = 1'b0;
        amp_hi = 50; amp_lo = -50;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("E_no_trig", trig, 0);
        end
        check("E_out0_held", out0, h0);
        check("E_out1_held", out1, h1);
        set_en(1'b1);
        wait_trig(40, t0);
        check("E_out0_new", out0, 400);
        check("E_out1_first", out1, 0);

        // reset pulse in the middle of a measurement
        wait_trig(20, t0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("F_out0_now", out0, 0);
        check("F_out1_now", out1, 0);
        check("F_trig_now", trig, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        trel = cyc;
        wait_trig(60, t0);
        check("F_gap_full_meas", (t0 - trel) >= 11, 1);
        check("F_out0", out0, 400);
        check("F_out1_first", out1, 0);

        // random phase toggles, samples, n_per, enable drops and resets
        gen_mode = 1;
        for (int k = 0; k < 4000; k++) begin
            @(posedge clk);
            #1;
            en    = ($urandom_range(99) != 0);
            rst_n = ($urandom_range(999) != 0);
        end
        @(posedge clk);
        #1 rst_n = 1'b1; en = 1'b1;
        gen_mode = 0;
        repeat (5) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
